// File: rtl/sap_1_pkg.sv
// rtl/sap_1_pkg.sv - SAP-1 opcodes, control-word bit indices, named control words and T-states.
package sap_1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // CON = {Cp, Ep, LmN, CEN, LiN, EiN, LaN, Ea, Su, Eu, LbN, LoN}
    localparam int CON_CP  = 11;
    localparam int CON_EP  = 10;
    localparam int CON_LMN = 9;
    localparam int CON_CEN = 8;
    localparam int CON_LIN = 7;
    localparam int CON_EIN = 6;
    localparam int CON_LAN = 5;
    localparam int CON_EA  = 4;
    localparam int CON_SU  = 3;
    localparam int CON_EU  = 2;
    localparam int CON_LBN = 1;
    localparam int CON_LON = 0;

    localparam logic [11:0] CW_IDLE     = 12'h3E3;
    localparam logic [11:0] CW_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] CW_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] CW_FETCH_T3 = 12'h263;
    localparam logic [11:0] CW_MEM_T4   = 12'h1A3;
    localparam logic [11:0] CW_LDA_T5   = 12'h2C3;
    localparam logic [11:0] CW_ADD_T5   = 12'h2E1;
    localparam logic [11:0] CW_ADD_T6   = 12'h3C7;
    localparam logic [11:0] CW_SUB_T6   = 12'h3CF;
    localparam logic [11:0] CW_OUT_T4   = 12'h3F2;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

endpackage

// File: rtl/sap_1_ring_counter.sv
// rtl/sap_1_ring_counter.sv - 6-state one-hot ring counter, falling-edge clocked, async clear, hold for halt.
module sap_1_ring_counter
    import sap_1_pkg::*;
(
    input  logic       i_clk_n,
    input  logic       i_clr,
    input  logic       i_hold,
    output logic [5:0] o_t
);

    logic [5:0] r_t;
    logic [5:0] w_next;

    always_ff @(negedge i_clk_n or posedge i_clr) begin
        if (i_clr) begin
            r_t <= T1;
        end else begin
            r_t <= w_next;
        end
    end

    // Any corrupted (non-one-hot) value recovers to T1 on the next edge.
    always_comb begin
        w_next = T1;
        if (i_hold) begin
            w_next = r_t;
        end else begin
            case (r_t)
                T1:      w_next = T2;
                T2:      w_next = T3;
                T3:      w_next = T4;
                T4:      w_next = T5;
                T5:      w_next = T6;
                T6:      w_next = T1;
                default: w_next = T1;
            endcase
        end
    end

    assign o_t = r_t;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// rtl/sap_1_controller_sequencer.sv - SAP-1 controller-sequencer: ring counter plus (T, opcode) control-word decode.
module sap_1_controller_sequencer
    import sap_1_pkg::*;
(
    input  logic        ClkN,
    input  logic        Clr,
    input  logic [3:0]  Opcode,
    output logic [11:0] CON,
    output logic        Hlt,
    output logic [5:0]  T
);

    logic        r_hlt;
    logic        w_hlt_req;
    logic        w_hold;
    logic [5:0]  w_t;
    logic [11:0] w_con;

    assign w_hlt_req = (w_t == T4) && (Opcode == OP_HLT);
    assign w_hold    = r_hlt | w_hlt_req;

    sap_1_ring_counter u_ring (
        .i_clk_n (ClkN),
        .i_clr   (Clr),
        .i_hold  (w_hold),
        .o_t     (w_t)
    );

    always_ff @(negedge ClkN or posedge Clr) begin
        if (Clr) begin
            r_hlt <= 1'b0;
        end else if (w_hlt_req) begin
            r_hlt <= 1'b1;
        end
    end

    // Clr and Hlt gate the decode so Cp can never pulse outside a live T2.
    always_comb begin
        w_con = CW_IDLE;
        if (!(Clr || r_hlt)) begin
            case (w_t)
                T1: w_con = CW_FETCH_T1;
                T2: w_con = CW_FETCH_T2;
                T3: w_con = CW_FETCH_T3;
                T4: begin
                    case (Opcode)
                        OP_LDA, OP_ADD, OP_SUB: w_con = CW_MEM_T4;
                        OP_OUT:                 w_con = CW_OUT_T4;
                        default:                w_con = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (Opcode)
                        OP_LDA:         w_con = CW_LDA_T5;
                        OP_ADD, OP_SUB: w_con = CW_ADD_T5;
                        default:        w_con = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (Opcode)
                        OP_ADD:  w_con = CW_ADD_T6;
                        OP_SUB:  w_con = CW_SUB_T6;
                        default: w_con = CW_IDLE;
                    endcase
                end
                default: w_con = CW_IDLE;
            endcase
        end
    end

    assign CON = w_con;
    assign Hlt = r_hlt;
    assign T   = w_t;

endmodule
